// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and FSM state types for the FIR control slice
package fir_pkg;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_DLEN     = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  typedef enum logic {
    W_IDLE,
    W_ACK
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/fir_axil_ctrl.sv
// rtl/fir_axil_ctrl.sv - AXI-Lite register/tap responder and tap BRAM owner for the FIR engine
module fir_axil_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start,
  input  logic                   eng_done,
  output logic [31:0]            data_length
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_DLEN = pADDR_WIDTH'(ADDR_DLEN);
  localparam logic [pADDR_WIDTH-1:0] A_TLO  = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_THI  = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * (Tape_Num - 1));

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  logic                   w_cool;
  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] reg_rd;
  logic                   r_first;
  logic                   r_tap_ok;
  logic                   ap_start_q;
  logic                   ap_done_q;
  logic                   ap_idle_q;
  logic [31:0]            dlen_q;
  logic                   w_go, r_go, w_ack, w_tap, r_tap;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= A_TLO) && (a <= A_THI) && (a[1:0] == 2'b00);
  endfunction

  // w_cool blocks the first idle cycle after an accept so a late-dropping master is not taken twice
  assign w_go  = (w_state == W_IDLE) && awvalid && wvalid && !w_cool;
  assign r_go  = (r_state == R_IDLE) && arvalid && !w_go;
  assign w_ack = (w_state == W_ACK);
  assign w_tap = w_ack && ap_idle_q && is_tap(w_addr);
  assign r_tap = (r_state == R_ADDR) && ap_idle_q && is_tap(r_addr);

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE: if (w_go) w_state_nx = W_ACK;
      W_ACK:  w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE: if (r_go) r_state_nx = R_ADDR;
      R_ADDR: r_state_nx = R_DATA;
      R_DATA: if (rready) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    awready = w_ack;
    wready  = w_ack;
    arready = (r_state == R_ADDR);
    rvalid  = (r_state == R_DATA);
    rdata   = '0;
    if (r_state == R_DATA)
      rdata = (r_first && r_tap_ok) ? tap_Do : rdata_q;
  end

  // engine owns the tap port for the whole busy window
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = w_data;
    if (!ap_idle_q) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (w_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = w_addr - A_TLO;
    end else if (r_tap) begin
      tap_EN = 1'b1;
      tap_A  = r_addr - A_TLO;
    end
  end

  always_comb begin
    reg_rd = '0;
    if (r_addr == A_CTRL) begin
      reg_rd[AP_START] = ap_start_q;
      reg_rd[AP_DONE]  = ap_done_q;
      reg_rd[AP_IDLE]  = ap_idle_q;
    end else if (r_addr == A_DLEN) begin
      reg_rd = pDATA_WIDTH'(dlen_q);
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      w_cool   <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      r_addr   <= '0;
      rdata_q  <= '0;
      r_first  <= 1'b0;
      r_tap_ok <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
      w_cool  <= w_ack;
      if (w_go) begin
        w_addr <= awaddr;
        w_data <= wdata;
      end
      if (r_go) r_addr <= araddr;
      if (r_state == R_ADDR) begin
        rdata_q  <= reg_rd;
        r_tap_ok <= r_tap;
        r_first  <= 1'b1;
      end else if (r_state == R_DATA) begin
        r_first <= 1'b0;
        // BRAM output is only valid for one cycle; hold it for a stalled rready
        if (r_first && r_tap_ok) rdata_q <= tap_Do;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      dlen_q     <= '0;
    end else begin
      ap_start_q <= 1'b0;
      if (w_ack && ap_idle_q) begin
        if (w_addr == A_CTRL && w_data[AP_START]) begin
          ap_start_q <= 1'b1;
          ap_idle_q  <= 1'b0;
          ap_done_q  <= 1'b0;
        end
        if (w_addr == A_DLEN) dlen_q <= 32'(w_data);
      end
      if (rvalid && rready && r_addr == A_CTRL) ap_done_q <= 1'b0;
      if (eng_done) begin
        ap_done_q <= 1'b1;
        ap_idle_q <= 1'b1;
      end
    end
  end

  assign ap_start    = ap_start_q;
  assign data_length = dlen_q;

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// tb/tb_fir_axil_ctrl.sv - directed self-checking bench for fir_axil_ctrl
`timescale 1ns/1ps
module tb_fir_axil_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic        awready, wready, arready, rvalid;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic        eng_tap_EN = 1'b0;
  logic [11:0] eng_tap_A = '0;
  logic        ap_start;
  logic        eng_done = 1'b0;
  logic [31:0] data_length;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int wready_cnt = 0;
  logic [31:0] bram [0:15];
  logic [31:0] exp_tap [0:10];

  fir_axil_ctrl dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
    .ap_start(ap_start), .eng_done(eng_done), .data_length(data_length)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bram[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  always @(posedge axis_clk) begin
    #1;
    if (tap_WE != 4'h0) we_cnt++;
    if (ap_start) start_cnt++;
    if (wready) wready_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, output int lat);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge axis_clk);
      if (wready) begin lat = i; break; end
    end
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output int lat);
    araddr = a; arvalid = 1'b1; rready = 1'b1; lat = 99; d = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge axis_clk);
      if (rvalid) begin lat = i; d = rdata; break; end
    end
    arvalid = 1'b0;
    @(negedge axis_clk);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d; int lat;
    axis_rst = 1'b1;
    repeat (2) @(negedge axis_clk);
    n_cmp++;
    if ({awready, wready, arready, rvalid, ap_start, tap_EN} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 000000", {awready, wready, arready, rvalid, ap_start, tap_EN});
    end
    n_cmp++;
    if ({rdata, tap_Di, tap_A, tap_WE, data_length} !== '0) begin
      n_bad++; $display("FAIL reset_data: rdata=%h tap_Di=%h tap_A=%h tap_WE=%h dlen=%h want all 0", rdata, tap_Di, tap_A, tap_WE, data_length);
    end
    axis_rst = 1'b0;
    @(negedge axis_clk);
    do_read(12'h000, d, lat);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL reset_ctrl_read: got %h want 00000004", d); end
    do_read(12'h010, d, lat);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_dlen_read: got %h want 00000000", d); end
  endtask

  task automatic test_config;
    logic [31:0] d; int lat;
    do_write(12'h010, 32'd600, lat);
    n_cmp++;
    if (lat !== 1) begin n_bad++; $display("FAIL dlen_wr_lat: got %0d want 1", lat); end
    do_read(12'h010, d, lat);
    n_cmp++;
    if (d !== 32'd600 || data_length !== 32'd600) begin
      n_bad++; $display("FAIL dlen_read: got %0d port %0d want 600", d, data_length);
    end
    for (int k = 0; k < 11; k++) begin
      do_write(12'(32'h20 + 4 * k), exp_tap[k], lat);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL tap_wr_lat[%0d]: got %0d want 1", k, lat); end
    end
    for (int k = 0; k < 11; k++) begin
      do_read(12'(32'h20 + 4 * k), d, lat);
      n_cmp++;
      if (d !== exp_tap[k] || lat !== 2) begin
        n_bad++; $display("FAIL tap_read[%0d]: got %h lat %0d want %h lat 2", k, d, lat, exp_tap[k]);
      end
    end
  endtask

  task automatic test_start_busy;
    logic [31:0] d; int lat; int we0;
    start_cnt = 0;
    do_write(12'h000, 32'h1, lat);
    repeat (3) @(negedge axis_clk);
    n_cmp++;
    if (start_cnt !== 1) begin n_bad++; $display("FAIL start_pulse: got %0d cycles want 1", start_cnt); end
    do_read(12'h000, d, lat);
    n_cmp++;
    if ((d & 32'hF) !== 32'h0) begin n_bad++; $display("FAIL busy_ctrl: got %h want 0", d & 32'hF); end
    eng_tap_EN = 1'b1; eng_tap_A = 12'h028;
    #1;
    n_cmp++;
    if ({tap_EN, tap_A, tap_WE} !== {1'b1, 12'h028, 4'h0}) begin
      n_bad++; $display("FAIL eng_mux: got EN=%b A=%h WE=%h want 1 028 0", tap_EN, tap_A, tap_WE);
    end
    @(negedge axis_clk);
    eng_tap_EN = 1'b0; eng_tap_A = '0;
    we0 = we_cnt;
    do_write(12'h024, 32'd99, lat);
    do_read(12'h024, d, lat);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL busy_tap_read: got %h want 0", d); end
    n_cmp++;
    if (we_cnt !== we0) begin n_bad++; $display("FAIL busy_tap_we: got %0d pulses want 0", we_cnt - we0); end
    do_write(12'h010, 32'd5, lat);
    do_read(12'h010, d, lat);
    n_cmp++;
    if (d !== 32'd600) begin n_bad++; $display("FAIL busy_dlen: got %0d want 600", d); end
  endtask

  task automatic test_done;
    logic [31:0] d; int lat;
    eng_done = 1'b1;
    @(negedge axis_clk);
    eng_done = 1'b0;
    do_read(12'h000, d, lat);
    n_cmp++;
    if (d !== 32'h6) begin n_bad++; $display("FAIL done_read: got %h want 00000006", d); end
    do_read(12'h000, d, lat);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL done_clear: got %h want 00000004", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; int lat; int we0; int wr0;
    we0 = we_cnt; wr0 = wready_cnt;
    awaddr = 12'h02C; wdata = 32'd123; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(negedge axis_clk);
    n_cmp++;
    if (we_cnt - we0 !== 1 || wready_cnt - wr0 !== 1) begin
      n_bad++; $display("FAIL held_valid: got %0d WE %0d wready want 1 1", we_cnt - we0, wready_cnt - wr0);
    end
    exp_tap[3] = 32'd123;
    do_read(12'h02C, d, lat);
    n_cmp++;
    if (d !== 32'd123) begin n_bad++; $display("FAIL held_readback: got %0d want 123", d); end
    awaddr = 12'h030; wdata = 32'd77; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h030; arvalid = 1'b1; rready = 1'b1;
    @(negedge axis_clk);
    n_cmp++;
    if ({wready, arready} !== 2'b10) begin n_bad++; $display("FAIL arb_first: got %b want 10", {wready, arready}); end
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (arready !== 1'b1) begin n_bad++; $display("FAIL arb_read_next: got %b want 1", arready); end
    @(negedge axis_clk);
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'd77) begin
      n_bad++; $display("FAIL arb_read_data: got rvalid %b rdata %0d want 1 77", rvalid, rdata);
    end
    arvalid = 1'b0;
    @(negedge axis_clk);
    rready = 1'b0;
    exp_tap[4] = 32'd77;
  endtask

  task automatic test_async_reset;
    logic [31:0] d; int lat;
    do_write(12'h000, 32'h1, lat);
    araddr = 12'h010; arvalid = 1'b1; rready = 1'b0;
    repeat (2) @(negedge axis_clk);
    arvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_rvalid: got %b want 1", rvalid); end
    #2 axis_rst = 1'b1;
    #1;
    n_cmp++;
    if ({rvalid, rdata, data_length} !== '0) begin
      n_bad++; $display("FAIL rst_async: got rvalid %b rdata %h dlen %h want 0", rvalid, rdata, data_length);
    end
    @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    do_read(12'h000, d, lat);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL rst_idle: got %h want 00000004", d); end
    for (int k = 0; k < 11; k++) begin
      do_read(12'(32'h20 + 4 * k), d, lat);
      n_cmp++;
      if (d !== exp_tap[k]) begin n_bad++; $display("FAIL rst_tap[%0d]: got %h want %h", k, d, exp_tap[k]); end
    end
  endtask

  initial begin
    exp_tap[0] = 32'd0;   exp_tap[1] = -32'sd10; exp_tap[2] = -32'sd9;  exp_tap[3] = 32'd23;
    exp_tap[4] = 32'd56;  exp_tap[5] = 32'd63;   exp_tap[6] = 32'd56;   exp_tap[7] = 32'd23;
    exp_tap[8] = -32'sd9; exp_tap[9] = -32'sd10; exp_tap[10] = 32'd0;
    test_reset();
    test_config();
    test_start_busy();
    test_done();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
